// File: rtl/button_pkg.sv
// Shared defaults and legal ranges for the push-button to LED controller.
// Sizing helper for the debounce counter.
package button_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DEBOUNCE_DEF    = 0;
    localparam int unsigned CNT_W_DEF       = 16;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned DEBOUNCE_MAX    = 65535;

    // Smallest counter width able to represent 0..cycles.
    function automatic int unsigned cnt_w_min(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser bringing an asynchronous level into the clk domain.
// All stages clear asynchronously on reset.
module sync_chain
    import button_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_led_ctrl.sv
// Drives an LED from a push-button: synchronise, optionally debounce, register.
// DEBOUNCE_CYCLES = 0 bypasses the filter entirely.
module button_led_ctrl
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic led
);

    // Parameter legality checked at elaboration.
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("button_led_ctrl: SYNC_STAGES out of range 2..4");
    end
    if (DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_deb
        $error("button_led_ctrl: DEBOUNCE_CYCLES out of range 0..65535");
    end
    if (CNT_W < cnt_w_min(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("button_led_ctrl: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic btn_s;
    logic led_q;
    logic led_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button_in),
        .q     (btn_s)
    );

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass

        always_comb begin
            led_d = btn_s;
        end

    end else begin : g_debounce

        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
        localparam logic [CNT_W-1:0] CNT_MAX  = '1;

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Count consecutive cycles where btn_s disagrees with led; commit on the last one.
        always_comb begin
            cnt_d = cnt_q;
            led_d = led_q;
            if (btn_s == led_q) begin
                cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
                led_d = btn_s;
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench: default (no debounce) instance plus a DEBOUNCE_CYCLES = 4 instance.
module tb_button_led_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic btn0;
    logic btn4;
    logic led0;
    logic led4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    button_led_ctrl u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .button_in (btn0),
        .led       (led0)
    );

    button_led_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .button_in (btn4),
        .led       (led4)
    );

    // Rising edges at 5, 15, 25 ...; align() lands at 10k+2.
    task automatic align();
        @(negedge clk);
        #2;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn0  = 1'b0;
        btn4  = 1'b0;
        #3;
        checks++;
        if (led0 !== 1'b0) $display("FAIL reset_led0: led=%b expected 0", led0);
        else passed++;
        #7;
        checks++;
        if (led4 !== 1'b0) $display("FAIL reset_led4: led=%b expected 0", led4);
        else passed++;
        #2;
        reset = 1'b0;
        #4;
        checks++;
        if (led0 !== 1'b0) $display("FAIL reset_release: led=%b expected 0", led0);
        else passed++;
    endtask

    task automatic test_press();
        align();
        btn0 = 1'b1;
        edge1();
        edge1();
        checks++;
        if (led0 !== 1'b0) $display("FAIL press_edge2: led=%b expected 0", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL press_edge3: led=%b expected 1", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL press_held: led=%b expected 1", led0);
        else passed++;
        #6;
        btn0 = 1'b0;
        edge1();
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL release_edge2: led=%b expected 1", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b0) $display("FAIL release_edge3: led=%b expected 0", led0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        align();
        btn0 = 1'b1;
        edge1();
        edge1();
        checks++;
        if (led0 !== 1'b0) $display("FAIL short_press_edge2: led=%b expected 0", led0);
        else passed++;
        #1;
        btn0 = 1'b0;
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL short_press_edge3: led=%b expected 1", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL short_press_edge4: led=%b expected 1", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b0) $display("FAIL short_release: led=%b expected 0", led0);
        else passed++;
    endtask

    task automatic test_reset_during_press();
        align();
        btn0 = 1'b1;
        repeat (3) edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL rdp_pressed: led=%b expected 1", led0);
        else passed++;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (led0 !== 1'b0) $display("FAIL rdp_async_clear: led=%b expected 0", led0);
        else passed++;
        #9;
        reset = 1'b0;
        edge1();
        edge1();
        checks++;
        if (led0 !== 1'b0) $display("FAIL rdp_relatch_edge2: led=%b expected 0", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL rdp_relatch_edge3: led=%b expected 1", led0);
        else passed++;
        #1;
        reset = 1'b1;
        #10;
        reset = 1'b0;
        btn0  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge1();
            checks++;
            if (led0 !== 1'b0) $display("FAIL rdp_joint_release[%0d]: led=%b expected 0", i, led0);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        align();
        btn0 = 1'b1;
        #5;
        btn0 = 1'b0;
        #5;
        btn0 = 1'b1;
        #5;
        btn0 = 1'b0;
        edge1();
        checks++;
        if (led0 !== 1'b1) $display("FAIL glitch_edge1: led=%b expected 1", led0);
        else passed++;
        edge1();
        checks++;
        if ($isunknown(led0)) $display("FAIL glitch_no_x: led=%b expected known", led0);
        else passed++;
        edge1();
        checks++;
        if (led0 !== 1'b0) $display("FAIL glitch_settle: led=%b expected 0", led0);
        else passed++;
    endtask

    task automatic test_debounce();
        align();
        btn4 = 1'b1;
        #20;
        btn4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            edge1();
            checks++;
            if (led4 !== 1'b0) $display("FAIL deb_short[%0d]: led=%b expected 0", i, led4);
            else passed++;
        end
        align();
        btn4 = 1'b1;
        repeat (5) edge1();
        checks++;
        if (led4 !== 1'b0) $display("FAIL deb_press_edge5: led=%b expected 0", led4);
        else passed++;
        edge1();
        checks++;
        if (led4 !== 1'b1) $display("FAIL deb_press_edge6: led=%b expected 1", led4);
        else passed++;
        #6;
        btn4 = 1'b0;
        repeat (5) edge1();
        checks++;
        if (led4 !== 1'b1) $display("FAIL deb_release_edge5: led=%b expected 1", led4);
        else passed++;
        edge1();
        checks++;
        if (led4 !== 1'b0) $display("FAIL deb_release_edge6: led=%b expected 0", led4);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_back_to_back();
        test_reset_during_press();
        test_glitch();
        test_debounce();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
